// File: rtl/door_lock_pkg.sv
// Shared types for the keypad door lock: FSM state codes, key classes and
// the key-priority decode used by the debouncer.
package door_lock_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_OPEN    = 3'd3,
    ST_SET     = 3'd4,
    ST_LOCKOUT = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    KEY_NONE  = 2'd0,
    KEY_DIGIT = 2'd1,
    KEY_STAR  = 2'd2,
    KEY_SHARP = 2'd3
  } key_class_e;

  // '*' beats '#' beats digit, but '*' and '#' together with no digit is
  // treated as a fumbled press and yields nothing.
  function automatic key_class_e key_decode(input logic chk, input logic star,
                                            input logic sharp);
    if (star && sharp && !chk) return KEY_NONE;
    if (star)                  return KEY_STAR;
    if (sharp)                 return KEY_SHARP;
    if (chk)                   return KEY_DIGIT;
    return KEY_NONE;
  endfunction

endpackage

// File: rtl/door_lock_ctrl_key_debounce.sv
// Synchronizes the keypad encoder outputs and turns each debounced key press
// into a single classified event strobe.
module key_debounce
  import door_lock_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DIGIT_W-1:0] digit_i,
  input  logic               chk_i,
  input  logic               star_i,
  input  logic               sharp_i,
  output logic               evt_o,
  output key_class_e         evt_class_o,
  output logic [DIGIT_W-1:0] evt_digit_o,
  output logic               held_o
);

  // Handshake: evt_o is a one-cycle strobe with no backpressure; evt_class_o
  // and evt_digit_o are valid while evt_o is high and the consumer must take
  // the event in that cycle or lose it.

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
  localparam int SW = DIGIT_W + 3;

  logic [SW-1:0]      sync1_q, sync2_q;
  logic [CW-1:0]      cnt_q;
  logic               held_q;
  logic               evt_q;
  key_class_e         cls_q;
  logic [DIGIT_W-1:0] dig_q;

  logic [DIGIT_W-1:0] s_digit;
  logic               s_chk, s_star, s_sharp;
  logic               key_any;
  key_class_e         s_class;

  assign s_digit = sync2_q[SW-1:3];
  assign s_chk   = sync2_q[2];
  assign s_star  = sync2_q[1];
  assign s_sharp = sync2_q[0];
  assign key_any = s_chk | s_star | s_sharp;
  assign s_class = key_decode(s_chk, s_star, s_sharp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {digit_i, chk_i, star_i, sharp_i};
      sync2_q <= sync1_q;
    end
  end

  // cnt_q counts consecutive cycles in the opposite level to held_q; reaching
  // the last count flips held_q, firing an event on the press side only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      held_q <= 1'b0;
      evt_q  <= 1'b0;
      cls_q  <= KEY_NONE;
      dig_q  <= '0;
    end else begin
      evt_q <= 1'b0;
      if (key_any != held_q) begin
        if (cnt_q == CNT_LAST) begin
          cnt_q  <= '0;
          held_q <= key_any;
          if (key_any) begin
            evt_q <= (s_class != KEY_NONE);
            cls_q <= s_class;
            dig_q <= s_digit;
          end
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign evt_o       = evt_q;
  assign evt_class_o = cls_q;
  assign evt_digit_o = dig_q;
  assign held_o      = held_q;

endmodule

// File: rtl/door_lock_ctrl.sv
// Keypad door-lock controller: collects a passcode entry from debounced key
// events, checks it, and sequences unlock, passcode change and lockout.
module door_lock_ctrl
  import door_lock_pkg::*;
#(
  parameter int unsigned               PW_LEN      = 4,
  parameter logic [PW_LEN*DIGIT_W-1:0] DEFAULT_PW  = 16'h1234,
  parameter int unsigned               DEBOUNCE    = 4,
  parameter int unsigned               MAX_FAIL    = 3,
  parameter int unsigned               OPEN_CYCLES = 1000,
  parameter int unsigned               LOCK_CYCLES = 5000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DIGIT_W-1:0] digit_i,
  input  logic               chk_i,
  input  logic               star_i,
  input  logic               sharp_i,
  output logic               unlock_o,
  output logic               alarm_o,
  output logic               err_o,
  output logic               set_done_o,
  output logic [2:0]         digit_cnt_o,
  output logic [1:0]         fail_cnt_o,
  output logic [2:0]         state_o
);

  localparam int BUF_W = PW_LEN * DIGIT_W;
  localparam int unsigned TMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [2:0]    PW_LEN_C   = 3'(PW_LEN);
  localparam logic [1:0]    MAX_FAIL_C = 2'(MAX_FAIL);
  localparam logic [TW-1:0] OPEN_T     = TW'(OPEN_CYCLES);
  localparam logic [TW-1:0] LOCK_T     = TW'(LOCK_CYCLES);

  logic               evt;
  key_class_e         evt_class;
  logic [DIGIT_W-1:0] evt_digit;
  logic               key_held;

  key_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_key_debounce (
    .clk         (clk),
    .rst_n       (rst_n),
    .digit_i     (digit_i),
    .chk_i       (chk_i),
    .star_i      (star_i),
    .sharp_i     (sharp_i),
    .evt_o       (evt),
    .evt_class_o (evt_class),
    .evt_digit_o (evt_digit),
    .held_o      (key_held)
  );

  state_e           state_q;
  logic [BUF_W-1:0] buf_q;
  logic [BUF_W-1:0] pw_q;
  logic [2:0]       cnt_q;
  logic [1:0]       fail_q;
  logic [TW-1:0]    timer_q;
  logic             unlock_q, alarm_q, err_q, set_done_q;

  logic             is_digit, is_star, is_sharp;
  logic             can_take;
  logic             match;
  logic [1:0]       fail_inc;
  logic [BUF_W-1:0] buf_shift;
  logic             timer_last;

  assign is_digit   = evt && (evt_class == KEY_DIGIT);
  assign is_star    = evt && (evt_class == KEY_STAR);
  assign is_sharp   = evt && (evt_class == KEY_SHARP);
  assign can_take   = is_digit && (cnt_q < PW_LEN_C);
  assign match      = (cnt_q == PW_LEN_C) && (buf_q == pw_q);
  assign fail_inc   = fail_q + 2'd1;
  assign buf_shift  = (buf_q << DIGIT_W) | BUF_W'(evt_digit);
  // Exit on the cycle the count would hit zero so the dwell is exactly the
  // loaded number of cycles.
  assign timer_last = (timer_q <= TW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      buf_q      <= '0;
      pw_q       <= DEFAULT_PW;
      cnt_q      <= '0;
      fail_q     <= '0;
      timer_q    <= '0;
      unlock_q   <= 1'b0;
      alarm_q    <= 1'b0;
      err_q      <= 1'b0;
      set_done_q <= 1'b0;
    end else begin
      err_q      <= 1'b0;
      set_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (is_digit) begin
            buf_q   <= BUF_W'(evt_digit);
            cnt_q   <= 3'd1;
            state_q <= ST_ENTRY;
          end
        end

        ST_ENTRY: begin
          if (can_take) begin
            buf_q <= buf_shift;
            cnt_q <= cnt_q + 3'd1;
          end else if (is_star) begin
            buf_q   <= '0;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else if (is_sharp) begin
            state_q <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          buf_q <= '0;
          cnt_q <= '0;
          if (match) begin
            fail_q   <= '0;
            timer_q  <= OPEN_T;
            unlock_q <= 1'b1;
            state_q  <= ST_OPEN;
          end else begin
            err_q  <= 1'b1;
            fail_q <= fail_inc;
            if (fail_inc >= MAX_FAIL_C) begin
              timer_q <= LOCK_T;
              alarm_q <= 1'b1;
              state_q <= ST_LOCKOUT;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end

        ST_OPEN: begin
          if (timer_last || is_sharp) begin
            unlock_q <= 1'b0;
            state_q  <= ST_IDLE;
          end else if (is_star) begin
            unlock_q <= 1'b0;
            buf_q    <= '0;
            cnt_q    <= '0;
            state_q  <= ST_SET;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end

        ST_SET: begin
          if (can_take) begin
            buf_q <= buf_shift;
            cnt_q <= cnt_q + 3'd1;
          end else if (is_sharp) begin
            if (cnt_q == PW_LEN_C) begin
              pw_q       <= buf_q;
              set_done_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
            buf_q   <= '0;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else if (is_star) begin
            buf_q   <= '0;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end
        end

        ST_LOCKOUT: begin
          if (timer_last) begin
            alarm_q <= 1'b0;
            fail_q  <= '0;
            state_q <= ST_IDLE;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end

        default: begin
          buf_q    <= '0;
          cnt_q    <= '0;
          unlock_q <= 1'b0;
          alarm_q  <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign unlock_o    = unlock_q;
  assign alarm_o     = alarm_q;
  assign err_o       = err_q;
  assign set_done_o  = set_done_q;
  assign digit_cnt_o = cnt_q;
  assign fail_cnt_o  = fail_q;
  assign state_o     = state_q;

  // key_held is exported by the debouncer for observation only.
  logic unused_ok;
  assign unused_ok = key_held;

endmodule

// File: tb/tb_door_lock_ctrl.sv
// Directed bench for door_lock_ctrl: stimulus pushes expected output events
// into a queue and a negedge monitor pops and compares them as they appear.
module tb_door_lock_ctrl;

  localparam logic [3:0] K_ERR   = 4'd1;
  localparam logic [3:0] K_SETD  = 4'd2;
  localparam logic [3:0] K_OPEN  = 4'd3;
  localparam logic [3:0] K_ALARM = 4'd4;

  logic       clk;
  logic       rst_n;
  logic [3:0] digit;
  logic       chk, star, sharp;
  logic       unlock_o, alarm_o, err_o, set_done_o;
  logic [2:0] digit_cnt_o;
  logic [1:0] fail_cnt_o;
  logic [2:0] state_o;

  logic [15:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int unl_cnt  = 0;
  int alm_cnt  = 0;

  door_lock_ctrl #(
    .PW_LEN      (4),
    .DEFAULT_PW  (16'h1234),
    .DEBOUNCE    (2),
    .MAX_FAIL    (3),
    .OPEN_CYCLES (20),
    .LOCK_CYCLES (30)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digit_i     (digit),
    .chk_i       (chk),
    .star_i      (star),
    .sharp_i     (sharp),
    .unlock_o    (unlock_o),
    .alarm_o     (alarm_o),
    .err_o       (err_o),
    .set_done_o  (set_done_o),
    .digit_cnt_o (digit_cnt_o),
    .fail_cnt_o  (fail_cnt_o),
    .state_o     (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ev(input logic [3:0] kind, input int data);
    return {kind, 12'(data)};
  endfunction

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic sb_check(input string name, input logic [15:0] obs);
    logic [15:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: unexpected event %h, nothing expected", name, obs);
    end else begin
      e = exp_q.pop_front();
      if (e !== obs) begin
        failures++;
        $display("FAIL %s: got event %h expected %h", name, obs, e);
      end
    end
  endtask

  // monitor: turns pulses and high-level windows into events
  always @(negedge clk) begin
    if (!rst_n) begin
      unl_cnt = 0;
      alm_cnt = 0;
    end else begin
      if (err_o) sb_check("err", {K_ERR, 10'd0, fail_cnt_o});
      if (set_done_o) sb_check("set_done", ev(K_SETD, 0));
      if (unlock_o) unl_cnt++;
      else if (unl_cnt != 0) begin
        sb_check("unlock_len", ev(K_OPEN, unl_cnt));
        unl_cnt = 0;
      end
      if (alarm_o) alm_cnt++;
      else if (alm_cnt != 0) begin
        sb_check("alarm_len", ev(K_ALARM, alm_cnt));
        alm_cnt = 0;
      end
    end
  end

  // driver tasks
  task automatic press_raw(input logic [3:0] d, input logic c, input logic s,
                           input logic h, input int hold);
    @(posedge clk);
    #1;
    digit = d; chk = c; star = s; sharp = h;
    repeat (hold) @(posedge clk);
    #1;
    digit = 4'd0; chk = 1'b0; star = 1'b0; sharp = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic press_digit(input logic [3:0] d);
    press_raw(d, 1'b1, 1'b0, 1'b0, 6);
  endtask

  task automatic press_star();
    press_raw(4'd0, 1'b0, 1'b1, 1'b0, 6);
  endtask

  task automatic press_sharp();
    press_raw(4'd0, 1'b0, 1'b0, 1'b1, 6);
  endtask

  task automatic enter_code(input logic [15:0] code);
    for (int i = 3; i >= 0; i--) press_digit(code[i*4 +: 4]);
    press_sharp();
  endtask

  initial begin
    rst_n = 1'b0;
    digit = 4'd0; chk = 1'b0; star = 1'b0; sharp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_unlock", unlock_o, 0);
    check("rst_alarm", alarm_o, 0);
    check("rst_err", err_o, 0);
    check("rst_set_done", set_done_o, 0);
    check("rst_state", state_o, 0);
    check("rst_digit_cnt", digit_cnt_o, 0);
    check("rst_fail_cnt", fail_cnt_o, 0);
    rst_n = 1'b1;

    // correct entry: unlock for exactly 20 cycles
    exp_q.push_back(ev(K_OPEN, 20));
    enter_code(16'h1234);
    #1;
    check("open_unlock", unlock_o, 1);
    check("open_state", state_o, 3);
    repeat (20) @(posedge clk);
    #1;
    check("open_done_state", state_o, 0);
    check("open_done_unlock", unlock_o, 0);

    // three failures -> lockout for 30 cycles
    exp_q.push_back(ev(K_ERR, 1));
    enter_code(16'h1235);
    #1;
    check("fail1_cnt", fail_cnt_o, 1);
    check("fail1_state", state_o, 0);
    exp_q.push_back(ev(K_ERR, 2));
    enter_code(16'h1235);
    #1;
    check("fail2_cnt", fail_cnt_o, 2);
    exp_q.push_back(ev(K_ERR, 3));
    exp_q.push_back(ev(K_ALARM, 30));
    enter_code(16'h1235);
    #1;
    check("lock_alarm", alarm_o, 1);
    check("lock_state", state_o, 5);
    press_digit(4'd1);
    #1;
    check("lock_ignore_cnt", digit_cnt_o, 0);
    check("lock_ignore_state", state_o, 5);
    repeat (20) @(posedge clk);
    #1;
    check("lock_end_state", state_o, 0);
    check("lock_end_fail", fail_cnt_o, 0);
    check("lock_end_alarm", alarm_o, 0);

    // short entry, then clear and retry
    exp_q.push_back(ev(K_ERR, 1));
    press_digit(4'd1); press_digit(4'd2); press_digit(4'd3); press_sharp();
    #1;
    check("short_state", state_o, 0);
    check("short_unlock", unlock_o, 0);
    check("short_fail", fail_cnt_o, 1);
    press_digit(4'd1); press_digit(4'd2); press_star();
    #1;
    check("clear_cnt", digit_cnt_o, 0);
    check("clear_state", state_o, 0);
    exp_q.push_back(ev(K_OPEN, 20));
    enter_code(16'h1234);
    #1;
    check("retry_unlock", unlock_o, 1);
    check("retry_fail", fail_cnt_o, 0);
    repeat (20) @(posedge clk);

    // passcode change; '*' lands 12 cycles into OPEN (6 left in '#' press
    // + 1 idle edge + 5-edge press latency)
    exp_q.push_back(ev(K_OPEN, 12));
    enter_code(16'h1234);
    press_star();
    #1;
    check("set_state", state_o, 4);
    check("set_unlock", unlock_o, 0);
    exp_q.push_back(ev(K_SETD, 0));
    enter_code(16'h9876);
    #1;
    check("set_done_state", state_o, 0);
    exp_q.push_back(ev(K_ERR, 1));
    enter_code(16'h1234);
    exp_q.push_back(ev(K_OPEN, 20));
    enter_code(16'h9876);
    repeat (20) @(posedge clk);
    exp_q.push_back(ev(K_OPEN, 12));
    enter_code(16'h9876);
    press_star();
    exp_q.push_back(ev(K_ERR, 0));
    press_digit(4'd9); press_digit(4'd8); press_sharp();
    #1;
    check("bad_set_state", state_o, 0);
    exp_q.push_back(ev(K_OPEN, 20));
    enter_code(16'h9876);
    repeat (20) @(posedge clk);

    // debounce: 1-cycle glitch, long hold, star+sharp together
    @(posedge clk);
    #1;
    digit = 4'd5; chk = 1'b1;
    @(posedge clk);
    #1;
    digit = 4'd0; chk = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("glitch_cnt", digit_cnt_o, 0);
    check("glitch_state", state_o, 0);
    press_raw(4'd7, 1'b1, 1'b0, 1'b0, 100);
    #1;
    check("hold_cnt", digit_cnt_o, 1);
    check("hold_state", state_o, 1);
    press_raw(4'd0, 1'b0, 1'b1, 1'b1, 6);
    #1;
    check("starsharp_cnt", digit_cnt_o, 1);
    check("starsharp_state", state_o, 1);
    press_star();
    #1;
    check("abort_state", state_o, 0);

    // reset mid-OPEN drops unlock at once and restores the default passcode
    enter_code(16'h9876);
    #1;
    check("pre_rst_unlock", unlock_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_unlock", unlock_o, 0);
    check("async_rst_state", state_o, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back(ev(K_OPEN, 20));
    enter_code(16'h1234);
    #1;
    check("post_rst_unlock", unlock_o, 1);
    repeat (25) @(posedge clk);
    #1;

    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/door_lock_ctrl.md
# door_lock_ctrl

Keypad door-lock controller that consumes the outputs of the 12-key BCD keypad encoder (4-bit digit code, any-digit flag, `*` and `#` flags). It synchronizes and debounces key activity into single press events, collects a PW_LEN-digit entry, checks it against a stored passcode, and drives the unlock and alarm outputs. It also sequences passcode change and lockout after repeated failures. It sits directly downstream of the keypad encoder and is the top-level sequential block of the lock.

## Interface
- `PW_LEN`, 4: passcode length in digits (1–7).
- `DEFAULT_PW`, 16'h1234: reset passcode, BCD, PW_LEN*4 bits, most significant digit first.
- `DEBOUNCE`, 4: consecutive stable cycles required to accept a press or release (≥1).
- `MAX_FAIL`, 3: failed checks that trigger lockout (1–3).
- `OPEN_CYCLES`, 1000: unlock duration in clocks.
- `LOCK_CYCLES`, 5000: lockout duration in clocks.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `digit` input 4: BCD key code from the encoder, valid when `chk`=1.
- `chk` input 1: a digit key 0–9 is pressed.
- `star` input 1: `*` key pressed.
- `sharp` input 1: `#` key pressed.
- `unlock` output 1: door release, high in OPEN.
- `alarm` output 1: high in LOCKOUT.
- `err` output 1: one-cycle pulse on a failed check or a rejected passcode set.
- `set_done` output 1: one-cycle pulse when a new passcode is stored.
- `digit_cnt` output 3: digits collected in the current entry.
- `fail_cnt` output 2: consecutive failed checks.
- `state` output 3: current FSM state code.

## Operation
- **Input conditioning.** All of `digit`, `chk`, `star`, `sharp` pass through a 2-flop synchronizer. Define `key_any = chk|star|sharp`.
- **Press event.** A press event fires once when `key_any` has been high for DEBOUNCE consecutive cycles. Its key value is latched in the same cycle.
- **Re-arm.** No further event fires until `key_any` has been low for DEBOUNCE consecutive cycles. A held key yields exactly one event.
- **Key decode priority.** `star` beats `sharp`, which beats digit. `star` and `sharp` together, with no digit, produce no event.
- **Entry buffer.** The buffer shifts left 4 bits and the new digit enters the LSBs. `digit_cnt` saturates at PW_LEN; digits beyond PW_LEN are ignored.
- **FSM states:** IDLE=0, ENTRY=1, CHECK=2, OPEN=3, SET=4, LOCKOUT=5.
  - IDLE: a digit loads the buffer, sets `digit_cnt`=1 and goes to ENTRY. `*` and `#` are ignored.
  - ENTRY: a digit is collected. `*` clears the buffer and count and goes to IDLE. `#` goes to CHECK.
  - CHECK (one cycle): a match requires `digit_cnt`==PW_LEN and buffer==passcode.
    - Match: `fail_cnt`←0, load the timer with OPEN_CYCLES, go to OPEN.
    - Mismatch: pulse `err` and increment `fail_cnt`. If `fail_cnt` reaches MAX_FAIL, load the timer with LOCK_CYCLES and go to LOCKOUT; otherwise go to IDLE.
    - The buffer and count are cleared on exit in either case.
  - OPEN: `unlock`=1 and the timer decrements.
    - Timer reaching 0 → IDLE.
    - `#` → IDLE immediately.
    - `*` → SET with the buffer cleared.
    - Digits are ignored.
  - SET: `unlock`=0 and digits are collected.
    - `#` with `digit_cnt`==PW_LEN: passcode←buffer, pulse `set_done`, go to IDLE.
    - `#` with `digit_cnt`≠PW_LEN: pulse `err`, passcode unchanged, go to IDLE.
    - `*` aborts to IDLE.
  - LOCKOUT: `alarm`=1 and all events are ignored. When the timer reaches 0, `fail_cnt`←0 and the FSM goes to IDLE.
- **Timer width.** The timer is $clog2(max(OPEN_CYCLES, LOCK_CYCLES)+1) bits and counts down.

## Timing
- **Reset values.** State IDLE, passcode=DEFAULT_PW, buffer=0, all counters 0. `unlock`, `alarm`, `err`, `set_done` are 0; `digit_cnt`=0, `fail_cnt`=0, `state`=0.
- **Reset mid-operation.** Asserting `rst_n` in any state (including OPEN or LOCKOUT) immediately forces these values. Debounce state is cleared, so a key held through reset release needs a full DEBOUNCE-cycle press before it is accepted.
- **Press latency.** The FSM state and `digit_cnt` change DEBOUNCE+3 rising edges after the first edge that samples `key_any`=1: 2 edges for synchronization, DEBOUNCE for debounce, 1 for the FSM.
- **CHECK outcome.** CHECK lasts exactly one cycle. The outcome is visible on the next edge: `unlock`, `alarm` and `err` rise in the cycle after CHECK.
- **OPEN and LOCKOUT duration.** OPEN lasts exactly OPEN_CYCLES cycles and LOCKOUT exactly LOCK_CYCLES cycles, unless exited early by `#`.
- **Events during CHECK.** A press event arriving while in CHECK is dropped.

## Structure
- **Package `door_lock_pkg`.** Holds the state enum with the encodings above, the digit width constant (4), and the key-class enum: NONE, DIGIT, STAR, SHARP.
- **Sub-module `key_debounce`.** Contains the synchronizer, the debounce counter, the one-shot event and key-class decode. It outputs `evt`, `evt_class` and `evt_digit`.
- **`door_lock_ctrl`.** Holds the FSM, entry buffer, passcode register, fail counter and timer.

## Test plan
Bench parameters: DEBOUNCE=2, OPEN_CYCLES=20, LOCK_CYCLES=30, default passcode 1234.
- **Correct entry.** Press 1,2,3,4,# (each held 6 cycles, released 6) → `unlock`=1 for exactly 20 cycles, then `state`=0.
- **Lockout.** Press 1,2,3,5,# three times → `err` pulses 3 times and `fail_cnt` reads 1 then 2. On the third failure `alarm`=1 for 30 cycles, and presses during lockout change nothing. Afterwards `fail_cnt`=0.
- **Short entry and clear.** Press 1,2,3,# → `err`, no unlock. Press 1,2,*,1,2,3,4,# → unlock.
- **Passcode change.** Unlock, then press *,9,8,7,6,# → `set_done` pulses. 1234# now fails; 9876# unlocks. Press *,9,8,# in OPEN → `err`, passcode still 9876.
- **Debounce.** A `chk` glitch lasting 1 cycle produces no event. A key held 100 cycles yields `digit_cnt`=1 only. `star`+`sharp` together are ignored.
- **Reset.** Assert `rst_n`=0 mid-OPEN → `unlock` drops asynchronously and the passcode reverts to 1234.
